greater_circuit_serial: RTL

Multi-cycle magnitude comparator that resolves the same unsigned "a greater than b" question as the parallel greater-than cascade, but in the opposite direction. It takes two WIDTH-bit operands in parallel and walks them one bit per clock, least-significant bit first. Each new, more-significant bit overrides the running verdict. It sits beside the combinational comparators as the low-area option for wide operands, with a start/busy/done handshake for the surrounding datapath.

---
 rtl/greater_circuit_pkg.sv | 27 ++
 rtl/greater_circuit_serial_cmp_cell.sv | 16 +
 rtl/greater_circuit_serial.sv | 127 ++++++++++++
 3 files changed

// File: rtl/greater_circuit_pkg.sv
// Shared types and the one-bit relation step used by the serial magnitude comparators.
package greater_circuit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } rel_e;

  // A disagreeing bit overrides whatever the less-significant bits decided.
  function automatic rel_e rel_step(rel_e cur, logic a_i, logic b_i);
    rel_e nxt;
    case ({a_i, b_i})
      2'b10:   nxt = REL_GT;
      2'b01:   nxt = REL_LT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/greater_circuit_serial_cmp_cell.sv
// Combinational one-bit step of an LSB-first serial comparator.
module serial_cmp_cell
  import greater_circuit_pkg::*;
(
  input  rel_e cur_rel,
  input  logic a_i,
  input  logic b_i,
  output rel_e next_rel
);

  // Apply the relation step to the current bit pair.
  always_comb begin
    next_rel = rel_step(cur_rel, a_i, b_i);
  end

endmodule

// File: rtl/greater_circuit_serial.sv
// LSB-first serial unsigned magnitude comparator with start/busy/done handshake.
module greater_circuit_serial
  import greater_circuit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [CW-1:0]    cnt_r;
  rel_e             rel_r;
  rel_e             rel_next_s;
  logic             last_bit_s;
  logic             busy_r;
  logic             done_r;
  logic             gt_r;
  logic             eq_r;
  logic             lt_r;

  serial_cmp_cell u_cell (
    .cur_rel  (rel_r),
    .a_i      (a_sh_r[0]),
    .b_i      (b_sh_r[0]),
    .next_rel (rel_next_s)
  );

  assign last_bit_s = (cnt_r == LAST_CNT);

  // Next-state logic; start is only looked at while idle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_bit_s) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and handshake flags, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand capture, bit walk and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r <= {WIDTH{1'b0}};
      b_sh_r <= {WIDTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
      rel_r  <= REL_EQ;
      gt_r   <= 1'b0;
      eq_r   <= 1'b0;
      lt_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r <= a;
            b_sh_r <= b;
            cnt_r  <= {CW{1'b0}};
            rel_r  <= REL_EQ;
          end
        end
        SHIFT: begin
          rel_r  <= rel_next_s;
          a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
          // Hold the counter at the terminal value so it never wraps.
          if (last_bit_s) begin
            gt_r <= (rel_next_s == REL_GT);
            eq_r <= (rel_next_s == REL_EQ);
            lt_r <= (rel_next_s == REL_LT);
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign gt   = gt_r;
  assign eq   = eq_r;
  assign lt   = lt_r;

endmodule
